// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator for the 4-bank byte-lane data memory.
// Rotates lanes between address order and bank order, sign/zero-extends loads,
// and performs read-modify-write for byte/half stores because the memory
// always writes all four lanes.
// Optional build macro: MISALIGN_TRAP_EN (reject misaligned half/word requests).
module mem_access_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_di,
  output logic              mem_wr,
  input  logic [31:0]       mem_do
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mem_a_reg;
  logic [31:0]       wbuf_reg;
  logic [31:0]       rdata_reg;
  logic [1:0]        k_reg;
  logic [1:0]        size_reg;
  logic              we_reg;
  logic              sext_reg;
  logic [15:0]       wdata_reg;
  logic              trap;
  logic [31:0]       aligned_word;
  logic [31:0]       load_value;
  logic [31:0]       store_image;

  // Rotate left by whole bytes: bank-ordered lanes -> address-ordered word.
  function automatic logic [31:0] rotl8(input logic [31:0] x, input logic [1:0] k);
    case (k)
      2'd0:    rotl8 = x;
      2'd1:    rotl8 = {x[23:0], x[31:24]};
      2'd2:    rotl8 = {x[15:0], x[31:16]};
      default: rotl8 = {x[7:0],  x[31:8]};
    endcase
  endfunction

  // Rotate right by whole bytes: address-ordered word -> bank-ordered lanes.
  function automatic logic [31:0] rotr8(input logic [31:0] x, input logic [1:0] k);
    rotr8 = rotl8(x, 2'd0 - k);
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic err_reg;

  // Half needs an even address, word (size 10/11) needs a 4-byte-aligned one.
  assign trap = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  assign err  = err_reg;

  // Error flag is raised on a rejected accept and dropped as DONE is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state_reg == S_IDLE && req) begin
      err_reg <= trap;
    end else if (state_reg == S_DONE) begin
      err_reg <= 1'b0;
    end
  end
`else
  assign trap = 1'b0;
  assign err  = 1'b0;
`endif

  assign ready  = (state_reg == S_IDLE);
  assign done   = (state_reg == S_DONE);
  assign mem_wr = (state_reg == S_WRITE);
  assign mem_a  = mem_a_reg;
  assign mem_di = wbuf_reg;
  assign rdata  = rdata_reg;

  // Memory data brought into address order and shaped for load/merge.
  always_comb begin
    aligned_word = rotl8(mem_do, k_reg);
    case (size_reg)
      2'b00:   load_value = sext_reg ? {{24{aligned_word[31]}}, aligned_word[31:24]}
                                     : {24'd0, aligned_word[31:24]};
      2'b01:   load_value = sext_reg ? {{16{aligned_word[31]}}, aligned_word[31:16]}
                                     : {16'd0, aligned_word[31:16]};
      default: load_value = aligned_word;
    endcase
    if (size_reg == 2'b00) begin
      store_image = {wdata_reg[7:0], aligned_word[23:0]};
    end else begin
      store_image = {wdata_reg[15:0], aligned_word[15:0]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: word stores skip the read, loads skip the write.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          if (trap) begin
            state_next = S_DONE;
          end else if (we && size[1]) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_READ:  state_next = S_CAPT;
      S_CAPT:  state_next = we_reg ? S_WRITE : S_DONE;
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, memory address/data registers and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a_reg <= '0;
      wbuf_reg  <= '0;
      rdata_reg <= '0;
      k_reg     <= '0;
      size_reg  <= '0;
      we_reg    <= 1'b0;
      sext_reg  <= 1'b0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req && !trap) begin
            mem_a_reg <= addr;
            k_reg     <= addr[1:0];
            size_reg  <= size;
            we_reg    <= we;
            sext_reg  <= sext;
            wdata_reg <= wdata[15:0];
            // Word stores need no read, so their lane image is ready now.
            if (we && size[1]) begin
              wbuf_reg <= rotr8(wdata, addr[1:0]);
            end
          end
        end
        S_CAPT: begin
          if (we_reg) begin
            wbuf_reg <= rotr8(store_image, k_reg);
          end else begin
            rdata_reg <= load_value;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
